uart_rx_deframer: RTL and testbench

- UART receiver: the downstream consumer of the serial transmitter's 8N1 frames (idle high, start 0, 8 data bits LSB first, stop 1).
- Recovers bytes from the asynchronous rxd line using 16x oversampling.
- Presents each recovered byte with a one-cycle valid strobe for downstream logic (hex display, LEDs, loopback checker).
- Sits beside the baud-rate generator on the board clock; it has its own internal tick divider.

---
 rtl/uart_rx_deframer_pkg.sv | 26 ++
 rtl/uart_rx_deframer_if.sv | 30 +++
 rtl/uart_rx_deframer_os_tick.sv | 35 +++
 rtl/uart_rx_deframer.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_deframer_pkg.sv
// Shared UART constants and state encodings for the receive deframer and the transmitter.
// UART_RX_PARITY_EN adds the PARITY state encoding used by 8E1 builds.
package uart_rx_deframer_pkg;

    localparam int unsigned OVS         = 16;
    localparam int unsigned DEFAULT_DIV = 326;
    localparam int unsigned TICK_W      = 12;

    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd3;
    localparam logic [2:0] StBreak  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] StParity = 3'd5;
`endif

    // Even parity over a data byte.
    function automatic logic parity8(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Receive-side UART bus: serial input plus recovered byte and status strobes.
// slave is the deframer side; master is the line driver / byte consumer side.
interface uart_rx_deframer_if;

    logic       rxd;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        output rxd,
        input  dout,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output dout,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );

endinterface

// File: rtl/uart_rx_deframer_os_tick.sv
// Oversample tick divider: counts 0..DIV-1, pulses tick at DIV-1, synchronous clear realigns phase.
// Reusable by the transmitter's baud generator.
module uart_rx_deframer_os_tick
    import uart_rx_deframer_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_W-1:0] LastCount = TICK_W'(DIV - 1);

    logic [TICK_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LastCount);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: 16x oversampled 8N1 deframer with one-clock valid / frame_err strobes.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity_err strobe.
module uart_rx_deframer
    import uart_rx_deframer_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_deframer_if.slave   rx
);

    logic       rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0] state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       tick, tick_clr, start_edge;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       perr_q, perr_d;
`endif

    uart_rx_deframer_os_tick #(
        .DIV (DIV)
    ) u_os_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign start_edge = rx_prev_q & ~rx_s_q;

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        bcnt_d   = bcnt_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // Restart the divider so every sample lands at a fixed phase from the edge.
                if (start_edge) begin
                    state_d  = StStart;
                    scnt_d   = '0;
                    bcnt_d   = '0;
                    tick_clr = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (scnt_q == MID_SAMPLE) begin
                        scnt_d  = '0;
                        state_d = rx_s_q ? StIdle : StData;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (scnt_q == LAST_SAMPLE) begin
                        shreg_d[bcnt_q] = rx_s_q;
                        scnt_d          = '0;
                        bcnt_d          = bcnt_q + 1'b1;
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (scnt_q == LAST_SAMPLE) begin
                        par_d   = rx_s_q;
                        scnt_d  = '0;
                        state_d = StStop;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (scnt_q == LAST_SAMPLE) begin
                        dout_d = shreg_q;
                        scnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        perr_d = parity8(shreg_q) ^ par_q;
`endif
                        if (rx_s_q) begin
                            valid_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= StIdle;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx.rxd;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx.dout      = dout_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at DIV=4 (64 clk per bit).
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deframer;
    import uart_rx_deframer_pkg::*;

    localparam int unsigned TB_DIV  = 4;
    localparam int          BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle_bits;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_deframer_if bus ();

    uart_rx_deframer #(
        .DIV (TB_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         vcnt = 0, fcnt = 0, pcnt = 0, pcoin = 0, both_total = 0;
    int         vtime[2];
    logic [7:0] vdata[2];
    int         n_chk = 0, n_pass = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.valid) begin
            if (vcnt < 2) begin
                vtime[vcnt] = cyc;
                vdata[vcnt] = bus.dout;
            end
            vcnt++;
        end
        if (bus.frame_err) fcnt++;
        if (bus.parity_err) pcnt++;
        if (bus.parity_err && (bus.valid || bus.frame_err)) pcoin++;
        if (bus.valid && bus.frame_err) both_total++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_counts();
        vcnt  = 0;
        fcnt  = 0;
        pcnt  = 0;
        pcoin = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.rxd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        repeat (bits) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par !== 1'bx) bus.rxd = data[7];
`endif
        send_bit(stop);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h38, 1'b1, 2, 1, 0, 8'h38};
        vecs[1] = '{8'h96, 1'b1, 2, 1, 0, 8'h96};
        vecs[2] = '{8'hC3, 1'b0, 2, 0, 1, 8'hC3};
        vecs[3] = '{8'h00, 1'b1, 1, 1, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};

        bus.rxd = 1'b1;
        reset   = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_dout", bus.dout, 8'h00);
        check("reset_valid", bus.valid, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_parity_err", bus.parity_err, 0);
        check("reset_busy", bus.busy, 0);
        reset = 1'b0;
        idle(2);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            clear_counts();
            send_frame(vecs[i].data, vecs[i].stop, parity8(vecs[i].data));
            idle(vecs[i].idle_bits);
            check($sformatf("vec%0d_valid_count", i), vcnt, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr_count", i), fcnt, vecs[i].exp_ferr);
            check($sformatf("vec%0d_perr_count", i), pcnt, 0);
            check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_busy", i), bus.busy, 0);
        end

        // Back-to-back frames with no idle gap
        clear_counts();
        send_frame(8'hA5, 1'b1, parity8(8'hA5));
        send_frame(8'h5A, 1'b1, parity8(8'h5A));
        idle(2);
        check("b2b_valid_count", vcnt, 2);
        check("b2b_first_dout", vdata[0], 8'hA5);
        check("b2b_second_dout", vdata[1], 8'h5A);
        check("b2b_spacing", vtime[1] - vtime[0], FRAME_BITS * BIT_CLK);

        // False start: 20 clk low pulse
        clear_counts();
        bus.rxd = 1'b0;
        repeat (20) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        check("false_start_valid", vcnt, 0);
        check("false_start_ferr", fcnt, 0);
        check("false_start_busy", bus.busy, 0);
        send_frame(8'h96, 1'b1, parity8(8'h96));
        idle(2);
        check("after_false_valid", vcnt, 1);
        check("after_false_dout", bus.dout, 8'h96);

        // Bad stop bit followed by a held-low break
        clear_counts();
        send_frame(8'h48, 1'b0, parity8(8'h48));
        repeat (5) send_bit(1'b0);
        check("break_ferr_count", fcnt, 1);
        check("break_valid_count", vcnt, 0);
        check("break_dout", bus.dout, 8'h48);
        check("break_busy", bus.busy, 1);
        idle(2);
        check("break_exit_busy", bus.busy, 0);
        send_frame(8'h19, 1'b1, parity8(8'h19));
        idle(2);
        check("after_break_valid", vcnt, 1);
        check("after_break_ferr", fcnt, 1);
        check("after_break_dout", bus.dout, 8'h19);

        // Reset during bit 4 of 8'hFF
        clear_counts();
        send_bit(1'b0);
        repeat (4) send_bit(1'b1);
        bus.rxd = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_busy", bus.busy, 0);
        check("midreset_dout", bus.dout, 8'h00);
        reset = 1'b0;
        idle(2);
        check("midreset_valid", vcnt, 0);
        check("midreset_ferr", fcnt, 0);
        send_frame(8'h0F, 1'b1, parity8(8'h0F));
        idle(2);
        check("after_reset_valid", vcnt, 1);
        check("after_reset_dout", bus.dout, 8'h0F);

`ifdef UART_RX_PARITY_EN
        // Wrong parity bit: valid still fires, parity_err alongside
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2);
        check("par_bad_valid", vcnt, 1);
        check("par_bad_perr", pcnt, 1);
        check("par_bad_coincident", pcoin, 1);
        check("par_bad_dout", bus.dout, 8'h07);
        clear_counts();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2);
        check("par_good_valid", vcnt, 1);
        check("par_good_perr", pcnt, 0);
`endif

        check("valid_and_ferr_overlap", both_total, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
